// File: rtl/rr_quantum_scheduler.sv
// Round-robin arbiter for one shared resource. A grant is held until done, until the owner
// drops its request, or until a cycle quantum expires. A dead cycle always separates two grants.
module rr_quantum_scheduler #(
    parameter int N       = 4,
    parameter int QUANTUM = 8,
    parameter int CNT_W   = 4,
    parameter int ID_W    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    mask,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_vld,
    output logic            timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic             QLIM_EN = (QUANTUM != 0);
    localparam logic [CNT_W-1:0] QLAST   = CNT_W'((QUANTUM == 0) ? 0 : QUANTUM - 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic              gnt_vld_q, gnt_vld_d;
    logic              timeout_q, timeout_d;

    logic [N-1:0]      elig_s;
    logic              win_found_s;
    logic [ID_W-1:0]   win_id_s;
    logic [ID_W-1:0]   cand_s;
    logic              owner_req_s;
    logic              q_exp_s;
    logic              release_s;

    // Rotating-priority search: first eligible requester at or after ptr, wrapping.
    always_comb begin
        elig_s      = req & ~mask;
        win_found_s = 1'b0;
        win_id_s    = '0;
        cand_s      = '0;
        for (int i = 0; i < N; i++) begin
            cand_s = ID_W'((int'(ptr_q) + i) % N);
            if (!win_found_s && elig_s[cand_s]) begin
                win_found_s = 1'b1;
                win_id_s    = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and output decode; done outranks request loss, which outranks expiry.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_vld_d   = gnt_vld_q;
        timeout_d   = 1'b0;
        owner_req_s = req[gnt_id_q];
        q_exp_s     = QLIM_EN && (hold_cnt_q == QLAST);
        release_s   = done || !owner_req_s || q_exp_s;

        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (win_found_s) begin
                    state_d           = GRANT;
                    gnt_d             = '0;
                    gnt_d[win_id_s]   = 1'b1;
                    gnt_id_d          = win_id_s;
                    gnt_vld_d         = 1'b1;
                end else begin
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = '0;
                    ptr_d      = ID_W'((int'(gnt_id_q) + 1) % N);
                    timeout_d  = !done && owner_req_s;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            gnt_vld_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_vld_q  <= gnt_vld_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_quantum_scheduler.sv
// Self-checking bench: directed vector table, hand-written quantum sequences, and randomized
// traffic compared against a cycle-age reference model of the scheduler.
module tb_rr_quantum_scheduler;

    localparam int N       = 4;
    localparam int QUANTUM = 8;
    localparam int CNT_W   = 4;
    localparam int ID_W    = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    mask;
    logic            done;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_vld;
    logic            timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owner (-1 = none), cycles the owner has held the grant, rotation pointer.
    int m_owner = -1;
    int m_age   = 0;
    int m_ptr   = 0;
    int m_last  = 0;
    int m_to    = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] mask;
        logic       done;
        logic [3:0] e_gnt;
        logic [1:0] e_id;
        logic       e_vld;
        logic       e_to;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rr_quantum_scheduler #(
        .N(N), .QUANTUM(QUANTUM), .CNT_W(CNT_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .timeout(timeout)
    );

    function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] mk,
                                input logic d, input logic [3:0] eg, input logic [1:0] eid,
                                input logic ev, input logic et);
        vec_t v;
        v.rst = r; v.req = rq; v.mask = mk; v.done = d;
        v.e_gnt = eg; v.e_id = eid; v.e_vld = ev; v.e_to = et;
        vecs.push_back(v);
    endfunction

    function automatic void model_step();
        logic [3:0] e;
        logic       found;
        int         c;
        if (rst) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_last = 0; m_to = 0;
        end else if (m_owner < 0) begin
            m_to  = 0;
            e     = req & ~mask;
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (!found && e[c]) begin
                    found = 1'b1; m_owner = c; m_last = c; m_age = 1;
                end
            end
        end else if (done || !req[m_owner] || (QUANTUM != 0 && m_age == QUANTUM)) begin
            m_to    = (!done && req[m_owner]) ? 1 : 0;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_age   = 0;
        end else begin
            m_age = m_age + 1;
            m_to  = 0;
        end
    endfunction

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] mk, input logic d);
        rst = r; req = rq; mask = mk; done = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                         input logic ev, input logic et);
        n_checks++;
        if (gnt === eg && gnt_id === eid && gnt_vld === ev && timeout === et) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got gnt=%b id=%0d vld=%b to=%b, expected gnt=%b id=%0d vld=%b to=%b",
                     name, gnt, gnt_id, gnt_vld, timeout, eg, eid, ev, et);
        end
    endtask

    task automatic check_model(input string name);
        logic [3:0] one;
        logic [3:0] eg;
        one = 4'b0001;
        eg  = (m_owner >= 0) ? (one << m_owner) : 4'b0000;
        check(name, eg, 2'(m_last), (m_owner >= 0), m_to[0]);
    endtask

    initial begin
        logic [3:0] rq_r;
        logic [3:0] mk_r;
        rst = 1'b1; req = 4'b0000; mask = 4'b0000; done = 1'b0;

        //   rst   req      mask     done  gnt      id     vld   to
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b0, 4'b0110, 4'b0010, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(1'b0, 4'b0110, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(1'b0, 4'b0110, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(1'b0, 4'b0110, 4'b0110, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        add(1'b0, 4'b1001, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(1'b0, 4'b1001, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
        add(1'b0, 4'b1001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(1'b1, 4'b1000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].mask, vecs[i].done);
            check($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_id, vecs[i].e_vld, vecs[i].e_to);
        end

        // Quantum expiry: requester 0 keeps its request, holds exactly QUANTUM cycles.
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        for (int k = 1; k <= QUANTUM; k++) begin
            step(1'b0, 4'b0011, 4'b0000, 1'b0);
            check($sformatf("quantum_hold%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0011, 4'b0000, 1'b0);
        check("quantum_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        step(1'b0, 4'b0011, 4'b0000, 1'b0);
        check("after_timeout", 4'b0010, 2'd1, 1'b1, 1'b0);

        // done in the final quantum cycle wins over expiry; ptr still advances past owner 1.
        for (int k = 2; k <= QUANTUM; k++) begin
            step(1'b0, 4'b0011, 4'b0000, 1'b0);
            check($sformatf("hold1_%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0011, 4'b0000, 1'b1);
        check("done_vs_expiry", 4'b0000, 2'd1, 1'b0, 1'b0);
        step(1'b0, 4'b0011, 4'b0000, 1'b0);
        check("ptr_wrap_after_done", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Randomized traffic against the reference model.
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        check_model("rand_reset");
        rq_r = 4'b0000;
        mk_r = 4'b0000;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(3, 0) == 0) rq_r = 4'($urandom_range(15, 0));
            if ($urandom_range(7, 0) == 0) mk_r = 4'($urandom_range(15, 0));
            step(($urandom_range(99, 0) == 0), rq_r, mk_r, ($urandom_range(9, 0) == 0));
            check_model($sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
